// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and pulse-width arithmetic for the servo PWM block
// Purpose: default timing constants, command width, and the command-to-width mapping
//          used by the RTL and by the bench model.
// Ports: none (package).
package servo_pkg;

  localparam int unsigned FRAME_CYC   = 2_000_000;
  localparam int unsigned MIN_CYC     = 100_000;
  localparam int unsigned STEP_CYC    = 391;
  localparam int          CMD_W       = 8;
  localparam int          CNT_W       = 21;
  localparam logic [CMD_W-1:0] DEFAULT_CMD = 8'd128;

  // High time in cycles for a given command: MIN + cmd * STEP, unsigned, no saturation.
  function automatic int unsigned servo_width(input int unsigned min_cyc,
                                              input int unsigned step_cyc,
                                              input logic [CMD_W-1:0] cmd);
    return min_cyc + 32'(cmd) * step_cyc;
  endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// rtl/servo_pwm_gen_if.sv - command strobe bundle from the controller into the PWM generator
// Purpose: carries the truncated command and its one-cycle valid strobe.
// Signals: listo - command valid this cycle; cmd - unsigned pulse command.
// Modports: master (controller side, drives), slave (PWM generator side, samples).
interface servo_pwm_gen_if;
  import servo_pkg::*;

  logic             listo;
  logic [CMD_W-1:0] cmd;

  modport master (output listo, output cmd);
  modport slave  (input  listo, input  cmd);

endinterface

// File: rtl/servo_frame_cnt.sv
// rtl/servo_frame_cnt.sv - servo frame counter with run handling and frame tick
// Purpose: counts cycles within a frame while running, wraps at FRAME_CYC-1, restarts a
//          frame on the first edge after enable, and registers the frame tick.
// Ports: clk, rst (sync active-low) | en_i run enable | frame_start_o the coming edge
//        begins a frame | run_next_o, cnt_next_o next-state run flag and count |
//        frame_tick_o registered tick, high while run==1 and cnt==0.
module servo_frame_cnt #(
  parameter int unsigned FRAME_CYC = servo_pkg::FRAME_CYC,
  parameter int          CNT_W     = servo_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic             frame_start_o,
  output logic             run_next_o,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             frame_tick_o
);
  import servo_pkg::*;

  if ((64'd1 << CNT_W) <= 64'(FRAME_CYC)) begin : g_bad_cnt_w
    $error("servo_frame_cnt: CNT_W too narrow for FRAME_CYC");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYC - 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // A frame starts on the wrap edge or on the first enabled edge after being parked.
  // Dropping enable parks the counter at zero immediately, truncating any pulse.
  always_comb begin
    run_d = en_i;
    cnt_d = cnt_q;
    start = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (!run_q || (cnt_q == LAST_CNT)) begin
      cnt_d = '0;
      start = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Tick is registered from next-state values so it lines up with the cnt==0 cycle.
  always_comb begin
    tick_d = run_d && (cnt_d == '0);
  end

  assign frame_start_o = start;
  assign run_next_o    = run_d;
  assign cnt_next_o    = cnt_d;
  assign frame_tick_o  = tick_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - double-buffered servo PWM generator
// Purpose: captures strobed commands into a pending buffer, applies them only at frame
//          starts, and drives a registered pulse whose width is MIN + cmd*STEP cycles.
// Ports: clk, rst (sync active-low) | en run enable | cmd_if (slave) listo/cmd strobe |
//        pwm registered pulse | frame_tick one cycle per frame | cmd_act active command.
module servo_pwm_gen #(
  parameter int unsigned FRAME_CYC   = servo_pkg::FRAME_CYC,
  parameter int unsigned MIN_CYC     = servo_pkg::MIN_CYC,
  parameter int unsigned STEP_CYC    = servo_pkg::STEP_CYC,
  parameter logic [7:0]  DEFAULT_CMD = servo_pkg::DEFAULT_CMD,
  parameter int          CNT_W       = servo_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  servo_pwm_gen_if.slave             cmd_if,
  output logic                       pwm,
  output logic                       frame_tick,
  output logic [servo_pkg::CMD_W-1:0] cmd_act
);
  import servo_pkg::*;

  if ((64'(MIN_CYC) + 64'd255 * 64'(STEP_CYC)) >= 64'(FRAME_CYC)) begin : g_bad_width
    $error("servo_pwm_gen: widest pulse does not fit inside a frame");
  end

  localparam logic [CNT_W-1:0] DEFAULT_WIDTH = CNT_W'(servo_width(MIN_CYC, STEP_CYC, DEFAULT_CMD));

  logic [CMD_W-1:0] pending_q, pending_d;
  logic [CMD_W-1:0] cmd_act_q, cmd_act_d;
  logic [CMD_W-1:0] src;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] cnt_next;
  logic             pwm_q, pwm_d;
  logic             run_next;
  logic             frame_start;

  servo_frame_cnt #(
    .FRAME_CYC (FRAME_CYC),
    .CNT_W     (CNT_W)
  ) u_frame_cnt (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .frame_start_o (frame_start),
    .run_next_o    (run_next),
    .cnt_next_o    (cnt_next),
    .frame_tick_o  (frame_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= DEFAULT_CMD;
      cmd_act_q <= DEFAULT_CMD;
      width_q   <= DEFAULT_WIDTH;
      pwm_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cmd_act_q <= cmd_act_d;
      width_q   <= width_d;
      pwm_q     <= pwm_d;
    end
  end

  // A strobe landing on the frame-start cycle bypasses the buffer so it is not lost
  // for a whole frame; otherwise the last captured command is used.
  always_comb begin
    src       = cmd_if.listo ? cmd_if.cmd : pending_q;
    pending_d = cmd_if.listo ? cmd_if.cmd : pending_q;
    cmd_act_d = cmd_act_q;
    width_d   = width_q;
    if (frame_start) begin
      cmd_act_d = src;
      width_d   = CNT_W'(servo_width(MIN_CYC, STEP_CYC, src));
    end
  end

  // Registered from next-state values so pwm reflects run/cnt/width of its own cycle.
  always_comb begin
    pwm_d = run_next && (cnt_next < width_d);
  end

  assign pwm     = pwm_q;
  assign cmd_act = cmd_act_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - self-checking bench for servo_pwm_gen
module tb_servo_pwm_gen;
  import servo_pkg::*;

  localparam int FRAME = 1000;
  localparam int MINC  = 100;
  localparam int STEP  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pwm;
  logic       frame_tick;
  logic [7:0] cmd_act;

  servo_pwm_gen_if cmd_if ();

  servo_pwm_gen #(
    .FRAME_CYC   (FRAME),
    .MIN_CYC     (MINC),
    .STEP_CYC    (STEP),
    .DEFAULT_CMD (8'd128),
    .CNT_W       (21)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cmd_if     (cmd_if),
    .pwm        (pwm),
    .frame_tick (frame_tick),
    .cmd_act    (cmd_act)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position within the current frame, the frame's command and
  // width, and the buffered command; updated from the inputs present at each edge.
  bit          m_valid = 0;
  bit          m_run;
  int          m_phase;
  int          m_width;
  int          m_act;
  int          m_pending;

  always @(posedge clk) begin
    int src;
    m_valid = 1;
    if (!rst) begin
      m_run     = 0;
      m_phase   = 0;
      m_pending = 128;
      m_act     = 128;
      m_width   = int'(servo_width(MINC, STEP, 8'd128));
    end else begin
      src = cmd_if.listo ? int'(cmd_if.cmd) : m_pending;
      if (!en) begin
        m_run   = 0;
        m_phase = 0;
      end else if (!m_run || m_phase == FRAME - 1) begin
        m_run   = 1;
        m_phase = 0;
        m_act   = src;
        m_width = int'(servo_width(MINC, STEP, 8'(src)));
      end else begin
        m_phase = m_phase + 1;
      end
      m_pending = src;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model pwm", {31'd0, pwm}, {31'd0, m_run && (m_phase < m_width)});
      chk("model tick", {31'd0, frame_tick}, {31'd0, m_run && (m_phase == 0)});
      chk("model cmd_act", {24'd0, cmd_act}, 32'(m_act));
    end
  end

  // Called at the negedge of a frame's first cycle; returns at the next frame's first cycle.
  task automatic measure_frame(input int exp_high, input int exp_act, input string name,
                               input int sp, input logic [7:0] sc);
    int high = 0;
    int shape_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 0) begin
        chk({name, " tick"}, {31'd0, frame_tick}, 32'd1);
        chk({name, " cmd_act"}, {24'd0, cmd_act}, 32'(exp_act));
      end
      if (pwm === 1'b1) high++;
      if ((pwm === 1'b1) != (i < exp_high)) shape_bad++;
      cmd_if.listo = (i == sp);
      if (i == sp) cmd_if.cmd = sc;
      @(negedge clk);
    end
    cmd_if.listo = 1'b0;
    chk({name, " high"}, 32'(high), 32'(exp_high));
    chk({name, " shape"}, 32'(shape_bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    en = 1'b0;
    cmd_if.listo = 1'b0;
    cmd_if.cmd = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst pwm", {31'd0, pwm}, 32'd0);
    chk("rst tick", {31'd0, frame_tick}, 32'd0);
    chk("rst cmd_act", {24'd0, cmd_act}, 32'd128);

    rst = 1'b1;
    en = 1'b1;
    @(negedge clk);
    measure_frame(356, 128, "f0 default", -1, 8'd0);
    measure_frame(356, 128, "f1 strobe0 mid", 500, 8'd0);
    measure_frame(100, 0, "f2 cmd0", 300, 8'd255);
    measure_frame(610, 255, "f3 cmd255", -1, 8'd0);
    measure_frame(610, 255, "f4 wrap strobe", 999, 8'd10);
    measure_frame(120, 10, "f5 bypass", 5, 8'd20);
    measure_frame(140, 20, "f6 next", -1, 8'd0);

    repeat (50) @(negedge clk);
    chk("pre-drop pwm", {31'd0, pwm}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("drop pwm", {31'd0, pwm}, 32'd0);
    chk("drop tick", {31'd0, frame_tick}, 32'd0);
    repeat (20) @(negedge clk);
    cmd_if.listo = 1'b1;
    cmd_if.cmd = 8'd40;
    @(negedge clk);
    cmd_if.listo = 1'b0;
    repeat (10) @(negedge clk);
    chk("disabled tick", {31'd0, frame_tick}, 32'd0);
    chk("disabled cmd_act", {24'd0, cmd_act}, 32'd20);
    en = 1'b1;
    @(negedge clk);
    measure_frame(180, 40, "f7 reenable", -1, 8'd0);

    repeat (300) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst pwm", {31'd0, pwm}, 32'd0);
    chk("midrst tick", {31'd0, frame_tick}, 32'd0);
    chk("midrst cmd_act", {24'd0, cmd_act}, 32'd128);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    measure_frame(356, 128, "f8 after rst", -1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream stage of the IPD_trunc servo controller. Consumes its 8-bit truncated command and produces the servo PWM pulse train.
- Commands are double-buffered and applied only at frame boundaries, so a pulse is never cut or stretched mid-frame.
- Emits a one-cycle frame tick that the acquisition/controller chain uses as its sample cadence.

Parameters:
- FRAME_CYC, 2_000_000, clock cycles per servo frame (20 ms at 100 MHz).
- MIN_CYC, 100_000, pulse width in cycles for cmd=0 (1 ms).
- STEP_CYC, 391, extra cycles per command LSB (cmd=255 gives 199_705 cycles, about 2 ms).
- DEFAULT_CMD, 8'd128, command loaded at reset (servo centre).
- CNT_W, 21, frame counter width; must satisfy 2^CNT_W > FRAME_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-low.
- en  in  1  run enable; 0 parks the output low.
- listo  in  1  one-cycle strobe: cmd is valid this cycle.
- cmd  in  8  unsigned pulse command (trunc from the controller).
- pwm  out  1  servo pulse, registered.
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame.
- cmd_act  out  8  command governing the current frame.

Behaviour:
- Reset (rst=0 at a clk edge):
  - cnt=0, pending=DEFAULT_CMD, cmd_act=DEFAULT_CMD, width_q=MIN_CYC+DEFAULT_CMD*STEP_CYC.
  - pwm=0, frame_tick=0, run=0.
  - Reset overrides every other input, including mid-frame.
- Capture:
  - When listo=1, pending<=cmd at that edge.
  - Several strobes in one frame: the last one wins.
  - listo is captured even while en=0.
- Frame counter, while run=1:
  - cnt increments by 1 per cycle.
  - When cnt==FRAME_CYC-1, cnt wraps to 0. That wrap edge is the frame boundary.
- Start of a frame (boundary, or the first edge after run goes 0->1):
  - cnt<=0, cmd_act<=src, width_q<=MIN_CYC+src*STEP_CYC.
  - src is cmd if listo=1 in that same cycle (bypass), else pending.
- Width arithmetic:
  - Unsigned, CNT_W bits, no saturation.
  - Parameters must satisfy MIN_CYC+255*STEP_CYC < FRAME_CYC; an assertion checks this at elaboration.
- run: run<=en at each edge.
  - en 1->0 mid-frame: the next edge sets run=0, cnt=0, pwm=0. The partial pulse is truncated; this is accepted for a stop.
  - en 0->1: the next edge starts a fresh frame (state at frame start as above).
- pwm (flop): in every cycle, pwm==1 iff run==1 and cnt<width_q.
  - Pulse length is exactly width_q cycles, starting in the same cycle as frame_tick.
- frame_tick (flop): high exactly in cycles where run==1 and cnt==0.
  - Period is FRAME_CYC cycles; it is 0 while en=0.
- Latency:
  - A command strobed in frame N (including its boundary cycle) governs frame N+1.
  - cmd_act updates on the frame-start edge.
- Command extremes:
  - cmd=0 gives MIN_CYC high cycles.
  - cmd=255 gives MIN_CYC+255*STEP_CYC high cycles.
  - Never constantly high, never constantly low while running.

Decomposition:
- Shared package servo_pkg holds:
  - default constants FRAME_CYC, MIN_CYC, STEP_CYC, DEFAULT_CMD;
  - localparam CMD_W=8;
  - the width function MIN+cmd*STEP, reused by the bench model.
- One natural sub-module: servo_frame_cnt. It holds the counter, wrap, and run handling, and outputs cnt, frame_start, frame_tick.
- Compare, capture and width registers stay in the top module.

Test Plan (bench overrides FRAME_CYC=1000, MIN_CYC=100, STEP_CYC=2):
- Reset, then en=1 with no listo:
  - frame_tick every 1000 cycles;
  - pwm high exactly 356 cycles per frame;
  - cmd_act=128.
- listo with cmd=0 at frame mid-point:
  - the current frame keeps 356 high cycles;
  - the next frame has 100 high cycles, cmd_act=0.
- cmd=255:
  - next frame has 610 high cycles;
  - pwm falls at cnt=610 and stays low to 999.
- listo with cmd=10 on the wrap cycle (cnt=999):
  - the new frame uses 120 cycles immediately (bypass);
  - a second strobe cmd=20 at cnt=5 of that frame takes effect the frame after (140).
- en dropped at cnt=50 (pwm high):
  - pwm=0 and frame_tick silent from the next cycle;
  - listo with cmd=40 while disabled;
  - on re-enable: frame_tick on the first run cycle, 180 high cycles.
- rst=0 asserted at cnt=300 while en=1:
  - next edge gives pwm=0, cmd_act=128;
  - after release, the frame restarts from cnt=0 with 356 high cycles.
